// File: rtl/arbitro_vc_rr.sv
// Round-robin scheduler draining four VC FIFOs into two destination FIFOs.
// Three registered stages: grant/pop, read/mux, push/route.
module arbitro_vc_rr #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic [3:0]            vc_empty,
  input  logic [DATA_WIDTH-1:0] vc_data0,
  input  logic [DATA_WIDTH-1:0] vc_data1,
  input  logic [DATA_WIDTH-1:0] vc_data2,
  input  logic [DATA_WIDTH-1:0] vc_data3,
  input  logic [1:0]            d_almost_full,
  output logic [3:0]            vc_pop,
  output logic [1:0]            d_push,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  idle_out,
  output logic [CNT_WIDTH-1:0]  cnt_d0,
  output logic [CNT_WIDTH-1:0]  cnt_d1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]            ptr;
  logic                  s1_valid;
  logic [1:0]            s1_idx;
  logic [3:0]            eligible;
  logic                  can_grant;
  logic                  grant;
  logic [1:0]            grant_idx;
  logic [1:0]            pop_idx;
  logic [DATA_WIDTH-1:0] s1_word;

  // The VC popped this cycle is masked: its empty flag lags the pop by a cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    eligible  = ~vc_empty & ~vc_pop;
    can_grant = active_in & ~(|d_almost_full);
    grant     = 1'b0;
    grant_idx = ptr;
    // Scan from lowest priority to highest so the last hit is the winner.
    for (int k = 3; k >= 0; k--) begin
      if (eligible[ptr + 2'(k)]) begin
        grant     = can_grant;
        grant_idx = ptr + 2'(k);
      end
    end
  end

  always_comb begin
    pop_idx = 2'd0;
    case (vc_pop)
      4'b0010: pop_idx = 2'd1;
      4'b0100: pop_idx = 2'd2;
      4'b1000: pop_idx = 2'd3;
      default: pop_idx = 2'd0;
    endcase
  end

  always_comb begin
    s1_word = vc_data0;
    case (s1_idx)
      2'd1:    s1_word = vc_data1;
      2'd2:    s1_word = vc_data2;
      2'd3:    s1_word = vc_data3;
      default: s1_word = vc_data0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      vc_pop   <= '0;
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      d_push   <= '0;
      d_data   <= '0;
      cnt_d0   <= '0;
      cnt_d1   <= '0;
      idle_out <= 1'b1;
    end else begin
      vc_pop   <= grant ? (4'b0001 << grant_idx) : 4'b0000;
      if (grant) begin
        ptr <= grant_idx + 2'd1;
      end
      s1_valid <= |vc_pop;
      s1_idx   <= pop_idx;
      d_push   <= 2'b00;
      if (s1_valid) begin
        d_data <= s1_word;
        if (s1_word[DATA_WIDTH-1]) begin
          d_push <= 2'b10;
          cnt_d1 <= cnt_d1 + CNT_ONE;
        end else begin
          d_push <= 2'b01;
          cnt_d0 <= cnt_d0 + CNT_ONE;
        end
      end
      idle_out <= ~((|vc_pop) | s1_valid | (|d_push)) & (~(|eligible) | ~active_in);
    end
  end

endmodule

// File: tb/tb_arbitro_vc_rr.sv
// Randomized scoreboard bench for arbitro_vc_rr: VC FIFO models feed the DUT and a
// rule-level arbiter model predicts pops, routed pushes, counters and idle.
module tb_arbitro_vc_rr;

  localparam int DW    = 6;
  localparam int CW    = 5;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          active_in = 1'b1;
  logic [3:0]    vc_empty = 4'hf;
  logic [DW-1:0] vc_rd [4] = '{default: '0};
  logic [1:0]    d_almost_full = 2'b00;
  logic [3:0]    vc_pop;
  logic [1:0]    d_push;
  logic [DW-1:0] d_data;
  logic          idle_out;
  logic [CW-1:0] cnt_d0;
  logic [CW-1:0] cnt_d1;

  always #5 clk = ~clk;

  arbitro_vc_rr #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .active_in(active_in), .vc_empty(vc_empty),
    .vc_data0(vc_rd[0]), .vc_data1(vc_rd[1]), .vc_data2(vc_rd[2]), .vc_data3(vc_rd[3]),
    .d_almost_full(d_almost_full), .vc_pop(vc_pop), .d_push(d_push), .d_data(d_data),
    .idle_out(idle_out), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
  );

  // Word storage shared by the FIFO models (f_rd) and the scoreboard (s_rd).
  logic [DW-1:0] mem [4][DEPTH];
  int wr   [4];
  int f_rd [4];
  int s_rd [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [DW-1:0] w;
    int            due;
  } exp_t;
  exp_t exp_out[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic load(input int i, input logic [DW-1:0] w);
    mem[i][wr[i] % DEPTH] = w;
    wr[i]++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit fifos_empty();
    for (int i = 0; i < 4; i++) if (f_rd[i] != wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    tick(3);
    while (!(idle_out === 1'b1 && fifos_empty()) && n < max_cyc) begin
      tick(1);
      n++;
    end
    check("drain_timeout", 32'(n < max_cyc), 1);
    tick(2);
  endtask

  // VC FIFO models: read latency 1, empty flag updates after the popping edge.
  always @(posedge clk) begin
    int r;
    for (int i = 0; i < 4; i++) begin
      r = f_rd[i];
      if (vc_pop[i] === 1'b1 && r != wr[i]) begin
        vc_rd[i] <= mem[i][r % DEPTH];
        r++;
      end
      f_rd[i]     <= r;
      vc_empty[i] <= (r == wr[i]);
    end
  end

  // Reference model state: samples of the previous cycle plus abstract arbiter state.
  bit         p_reset = 1'b1;
  bit         p_active = 1'b0;
  logic [1:0] p_af = 2'b00;
  logic [3:0] p_empty = 4'hf;
  logic [3:0] p_pop = 4'h0;
  bit         p_idle = 1'b1;
  int         m_ptr = 0;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  always @(negedge clk) begin
    logic [3:0] elig;
    logic [3:0] e_pop;
    logic [1:0] e_push;
    exp_t       e;
    bit         pushed;
    int         v;
    int         g;
    if (mon_on) begin
      e_pop  = 4'h0;
      e_push = 2'b00;
      pushed = 1'b0;
      g      = -1;
      if (p_reset) begin
        exp_out.delete();
        m_ptr  = 0;
        m_cnt0 = 0;
        m_cnt1 = 0;
        check("rst_d_push", 32'(d_push), 0);
        check("rst_d_data", 32'(d_data), 0);
      end else begin
        elig = ~p_empty & ~p_pop;
        if (p_active && p_af == 2'b00) begin
          for (int k = 0; k < 4; k++) begin
            v = (m_ptr + k) % 4;
            if (g < 0 && elig[v]) g = v;
          end
        end
        if (g >= 0) begin
          e_pop = 4'(1 << g);
          m_ptr = (g + 1) % 4;
        end
        if (d_push !== 2'b00 || (exp_out.size() > 0 && exp_out[0].due <= cyc)) begin
          if (exp_out.size() == 0) begin
            check("unexpected_push", 32'(d_push), 0);
          end else begin
            e = exp_out.pop_front();
            e_push = e.w[DW-1] ? 2'b10 : 2'b01;
            check("push_cycle", 32'(cyc), 32'(e.due));
            check("d_push", 32'(d_push), 32'(e_push));
            check("d_data", 32'(d_data), 32'(e.w));
            if (e.w[DW-1]) m_cnt1++;
            else m_cnt0++;
            pushed = 1'b1;
          end
        end
      end
      check("vc_pop", 32'(vc_pop), 32'(e_pop));
      check("idle_out", 32'(idle_out), p_reset ? 1 : 32'(p_idle));
      check("cnt_d0", 32'(cnt_d0), 32'(m_cnt0 % 32));
      check("cnt_d1", 32'(cnt_d1), 32'(m_cnt1 % 32));
      if (g >= 0 && s_rd[g] != wr[g]) begin
        exp_out.push_back('{w: mem[g][s_rd[g] % DEPTH], due: cyc + 2});
        s_rd[g]++;
      end
      elig     = ~vc_empty & ~e_pop;
      p_idle   = !(exp_out.size() > 0 || pushed) && (elig == 4'h0 || !active_in);
      p_reset  = reset;
      p_active = active_in;
      p_af     = d_almost_full;
      p_empty  = vc_empty;
      p_pop    = e_pop;
      cyc++;
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic load_all(input int n);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < 4; i++) load(i, DW'($urandom));
  endtask

  initial begin
    // Reset held two cycles with every VC loaded and the block enabled.
    reset = 1'b1;
    active_in = 1'b1;
    load_all(6);
    @(posedge clk);
    mon_on = 1'b1;
    #1;
    tick(1);
    reset = 1'b0;
    wait_idle(200);

    // Single VC with three words, pointer at 0.
    pulse_reset();
    for (int j = 0; j < 3; j++) load(2, DW'($urandom));
    wait_idle(100);

    // Routing by destination bit.
    pulse_reset();
    load(1, 6'b100101);
    load(2, 6'b000011);
    wait_idle(100);
    check("route_cnt_d0", 32'(cnt_d0), 1);
    check("route_cnt_d1", 32'(cnt_d1), 1);

    // Backpressure on each almost-full flag during a stream.
    load_all(8);
    tick(5);
    d_almost_full = 2'b01;
    tick(6);
    d_almost_full = 2'b00;
    tick(3);
    d_almost_full = 2'b10;
    tick(3);
    d_almost_full = 2'b00;
    wait_idle(200);

    // Enable dropped mid-stream, then restored.
    load_all(8);
    tick(4);
    active_in = 1'b0;
    tick(5);
    active_in = 1'b1;
    wait_idle(200);

    // Reset mid-stream.
    load_all(8);
    tick(5);
    pulse_reset();
    wait_idle(200);

    // Counter wrap: 40 words to D0.
    pulse_reset();
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 4; i++) load(i, {1'b0, 5'($urandom)});
    wait_idle(200);
    check("wrap_cnt_d0", 32'(cnt_d0), 8);

    // Random traffic with random enable, backpressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ((wr[i] - f_rd[i]) < 12 && $urandom_range(0, 2) == 0) load(i, DW'($urandom));
      active_in     = ($urandom_range(0, 19) != 0);
      d_almost_full = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      reset         = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    reset = 1'b0;
    active_in = 1'b1;
    d_almost_full = 2'b00;
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
